inst_fetch_queue: RTL and testbench

Instruction fetch queue sitting directly upstream of the IF/ID pipeline register, inside the fetch stage. Issues sequential instruction-memory requests from a fetch PC, buffers in-order responses in a small FIFO, and presents one instruction per cycle to the pipeline. A control-transfer redirect from EXE retargets the fetch PC, empties the queue and discards every response still in flight.

---
 rtl/inst_fetch_queue_pkg.sv | 16 +
 rtl/inst_fetch_queue_if.sv | 27 ++
 rtl/inst_fetch_queue_fifo.sv | 48 ++++
 rtl/inst_fetch_queue.sv | 97 +++++++++
 tb/tb_inst_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam int          IFQ_DEPTH    = 4;
  localparam logic [63:0] IFQ_RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ifq_entry_s;

  function automatic logic [63:0] ifq_next_pc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue signal bundle: memory request/response, redirect/stall and IF/ID output.
interface inst_fetch_queue_if;
  import inst_fetch_queue_pkg::*;

  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

  modport master (
    input  stall, redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data,
    output mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst
  );

endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// ifq_fifo: synchronous (pc, inst) FIFO with clear; pointers carry an extra MSB
// so full and empty are distinguished without a separate flag.
module inst_fetch_queue_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  ifq_entry_s din,
  output ifq_entry_s dout,
  output logic [AW:0] count,
  output logic       empty
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  ifq_entry_s  mem [DEPTH];

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

  // The owner's credit scheme must make these impossible.
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) push |-> !full);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) pop |-> !empty);

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: sequential fetch issue, in-order response buffering,
// redirect flush with in-flight drop. IFQ_BYPASS_EN presents a kept response on an empty queue in the same cycle.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = IFQ_DEPTH,
  parameter logic [63:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic clk,
  input  logic rst,
  inst_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH+1);

  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_nxt;
  logic [CW-1:0] drop;
  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          resp_keep;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  ifq_entry_s    fifo_din;
  ifq_entry_s    fifo_dout;

  // Credit covers both buffered and outstanding entries, so the FIFO never overflows.
  assign occupancy         = {1'b0, count} + {1'b0, inflight};
  assign bus.mem_req_valid = !rst && (occupancy < (CW+1)'(DEPTH));
  assign bus.mem_req_addr  = fetch_pc;
  assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

  assign resp_keep    = bus.mem_resp_valid && (drop == '0) && !bus.redirect_valid;
  assign inflight_nxt = inflight + CW'(req_fire) - CW'(bus.mem_resp_valid);
  assign fifo_din     = '{pc: resp_pc, inst: bus.mem_resp_data};

`ifdef IFQ_BYPASS_EN
  logic bypass;

  assign bypass        = fifo_empty && resp_keep;
  assign bus.out_valid = !fifo_empty || bypass;
  assign bus.out_pc    = !fifo_empty ? fifo_dout.pc   : (bypass ? resp_pc : '0);
  assign bus.out_inst  = !fifo_empty ? fifo_dout.inst : (bypass ? bus.mem_resp_data : '0);
  assign fifo_pop      = !fifo_empty && !bus.stall && !bus.redirect_valid;
  // A bypassed word consumed this cycle must not also land in the queue.
  assign fifo_push     = resp_keep && !(bypass && !bus.stall);
`else
  assign bus.out_valid = !fifo_empty;
  assign bus.out_pc    = fifo_empty ? '0 : fifo_dout.pc;
  assign bus.out_inst  = fifo_empty ? '0 : fifo_dout.inst;
  assign fifo_pop      = !fifo_empty && !bus.stall && !bus.redirect_valid;
  assign fifo_push     = resp_keep;
`endif

  inst_fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (bus.redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (bus.redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        fetch_pc <= bus.redirect_pc;
        resp_pc  <= bus.redirect_pc;
        drop     <= inflight_nxt;
      end else begin
        if (req_fire)  fetch_pc <= ifq_next_pc(fetch_pc);
        if (resp_keep) resp_pc  <= ifq_next_pc(resp_pc);
        if (bus.mem_resp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  a_redirect_aligned: assert property (@(posedge clk) disable iff (rst)
    bus.redirect_valid |-> (bus.redirect_pc[1:0] == 2'b00));
  a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
    bus.mem_resp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: in-order memory model feeds expected
// (pc, inst) into a queue, a monitor pops and compares on every consumed output.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] TGT_A  = 64'h0000_0000_8000_1000;
  localparam logic [63:0] TGT_B  = 64'h0000_0000_8000_2000;
`ifdef IFQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_queue_if bus();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t      memq[$];
  ifq_entry_s sb[$];
  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int lat = 1;
  int epoch = 0;
  int resp_ep = 0;
  logic [63:0] iss_pc = RST_PC;
  logic [63:0] exp_pc = RST_PC;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Memory: in order, fixed latency per request, one response per cycle.
  always @(posedge clk) begin
    mreq_t m;
    #1;
    cyc++;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      m = memq.pop_front();
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = m.addr[31:0];
      resp_ep = m.ep;
    end
  end

  // Reference model: expected request address and expected kept responses.
  always @(negedge clk) begin
    if (rst) begin
      memq.delete();
      sb.delete();
      epoch++;
      iss_pc = RST_PC;
      exp_pc = RST_PC;
    end else begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        chk("req_addr", bus.mem_req_addr, iss_pc);
        memq.push_back('{addr: bus.mem_req_addr, due: cyc + lat, ep: epoch});
        iss_pc = iss_pc + 64'd4;
      end
      if (bus.mem_resp_valid && !bus.redirect_valid && resp_ep == epoch) begin
        sb.push_back('{pc: exp_pc, inst: exp_pc[31:0]});
        exp_pc = exp_pc + 64'd4;
      end
      if (bus.redirect_valid) begin
        sb.delete();
        epoch++;
        iss_pc = bus.redirect_pc;
        exp_pc = bus.redirect_pc;
      end
    end
  end

  // Monitor: every consumed head must match the next expected entry.
  always @(negedge clk) begin
    ifq_entry_s e;
    #1;
    if (rst !== 1'b1) begin
      if (bus.out_valid && !bus.stall && !bus.redirect_valid) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL pop_unexpected: got pc %h, expected no output", bus.out_pc);
        end else begin
          e = sb.pop_front();
          chk("out_pc", bus.out_pc, e.pc);
          chk("out_inst", 64'(bus.out_inst), 64'(e.inst));
        end
      end
      chk1("credit", (memq.size() + sb.size()) <= DEPTH, 1'b1);
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_req_ready = 1'b1;

    // Reset values
    repeat (3) step();
    settle();
    chk1("rst_req_valid", bus.mem_req_valid, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    chk("rst_out_inst", 64'(bus.out_inst), 64'd0);

    // Release: request at cycle 0, first output at cycle 2 (1 with bypass)
    step(); rst = 1'b0; settle();
    chk1("c0_out_valid", bus.out_valid, 1'b0);
    chk1("c0_req_valid", bus.mem_req_valid, 1'b1);
    chk("c0_req_addr", bus.mem_req_addr, RST_PC);
    step(); settle();
    chk1("c1_out_valid", bus.out_valid, BYPASS);
    step(); settle();
    chk1("c2_out_valid", bus.out_valid, 1'b1);
    chk("c2_out_pc", bus.out_pc, BYPASS ? RST_PC + 64'd4 : RST_PC);
    repeat (12) begin
      step(); settle();
      chk1("throughput", bus.out_valid, 1'b1);
    end

    // Memory not ready for 10 cycles: address holds, queue drains
    step(); bus.mem_req_ready = 1'b0; settle();
    chk1("nrdy_req_valid", bus.mem_req_valid, 1'b1);
    chk("nrdy_addr", bus.mem_req_addr, iss_pc);
    repeat (9) begin
      step(); settle();
      chk("nrdy_addr", bus.mem_req_addr, iss_pc);
    end
    chk1("nrdy_drained", bus.out_valid, 1'b0);

    // Stall with fast memory: exactly DEPTH entries buffered
    step(); bus.mem_req_ready = 1'b1; bus.stall = 1'b1;
    repeat (8) step();
    settle();
    chk1("stall_req_valid", bus.mem_req_valid, 1'b0);
    chk1("stall_out_valid", bus.out_valid, 1'b1);
    step(); bus.stall = 1'b0; bus.mem_req_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (bus.out_valid) n++;
      step();
    end
    chk("stall_buffered", 64'(n), 64'd4);

    // Three requests in flight, redirect as the first response returns
    lat = 3; bus.mem_req_ready = 1'b1;
    step(); step(); step();
    bus.mem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = TGT_A;
    step();
    bus.redirect_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    lat = 1;
    settle();
    chk1("redir_req_valid", bus.mem_req_valid, 1'b1);
    chk("redir_req_addr", bus.mem_req_addr, TGT_A);
    n = 0;
    while (!bus.out_valid && n < 12) begin
      step(); settle();
      n++;
    end
    chk1("redir_first_valid", bus.out_valid, 1'b1);
    chk("redir_first_pc", bus.out_pc, TGT_A);
    repeat (6) step();

    // Redirect while stalled with a full queue
    bus.stall = 1'b1;
    repeat (8) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = TGT_B;
    settle();
    chk1("rfull_out_valid", bus.out_valid, 1'b1);
    chk1("rfull_req_valid", bus.mem_req_valid, 1'b0);
    step();
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b0;
    settle();
    chk1("rfull_r1_out_valid", bus.out_valid, 1'b0);
    chk1("rfull_r1_req_valid", bus.mem_req_valid, 1'b1);
    chk("rfull_r1_req_addr", bus.mem_req_addr, TGT_B);
    step(); settle();
    chk1("rfull_r2_out_valid", bus.out_valid, BYPASS);
    step(); settle();
    chk1("rfull_r3_out_valid", bus.out_valid, 1'b1);
    chk("rfull_r3_out_pc", bus.out_pc, BYPASS ? TGT_B + 64'd4 : TGT_B);

    // Reset mid-stream with two requests in flight
    step(); lat = 2;
    repeat (6) step();
    rst = 1'b1;
    settle();
    chk1("mrst_req_valid", bus.mem_req_valid, 1'b0);
    step();
    rst = 1'b0;
    lat = 1;
    settle();
    chk1("mrst_out_valid", bus.out_valid, 1'b0);
    chk("mrst_out_pc", bus.out_pc, 64'd0);
    chk("mrst_out_inst", 64'(bus.out_inst), 64'd0);
    chk1("mrst_req_valid_after", bus.mem_req_valid, 1'b1);
    chk("mrst_req_addr", bus.mem_req_addr, RST_PC);
    step(); step(); settle();
    chk1("mrst_c2_out_valid", bus.out_valid, 1'b1);
    chk("mrst_c2_out_pc", bus.out_pc, BYPASS ? RST_PC + 64'd4 : RST_PC);

    // Drain and confirm nothing expected was left undelivered
    repeat (8) step();
    bus.mem_req_ready = 1'b0;
    repeat (6) step();
    settle();
    chk1("drain_out_valid", bus.out_valid, 1'b0);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
